delta_controller_output_storer: RTL and testbench

Downstream neighbour of the bias loader in the Delta controller. When a tile's accumulation is complete, it snapshots every PU output buffer (initially seeded with bias by the loader, then accumulated by the PUs). It then requantizes each OUT_BIN_LEN partial sum to BIN_LEN with optional ReLU and saturation, packs OUTPUT_CHANNEL results per 32-bit word, and writes one word per PU to DRAM. It pulses `finished` so the top controller can start the next tile's bias load.

---
 rtl/delta_pkg.sv | 54 +++++
 rtl/delta_controller_output_storer_if.sv | 28 ++
 rtl/delta_requant_pack.sv | 15 +
 rtl/delta_controller_output_storer.sv | 115 +++++++++++
 tb/tb_delta_controller_output_storer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/delta_pkg.sv
// Shared constants, FSM encoding and the requantization helper for the
// Delta controller output storer.
package delta_pkg;

  localparam int PU_NUM         = 8;
  localparam int OUTPUT_CHANNEL = 4;
  localparam int BIN_LEN        = 8;
  localparam int OUT_BIN_LEN    = 16;
  localparam int WORD_W         = OUTPUT_CHANNEL * BIN_LEN;
  localparam int PU_IDX_W       = $clog2(PU_NUM);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SNAP    = 3'd1,
    ST_PACK    = 3'd2,
    ST_WR      = 3'd3,
    ST_WAIT_WR = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } storer_state_t;

  typedef logic [OUTPUT_CHANNEL-1:0][OUT_BIN_LEN-1:0] pu_ob_t;
  typedef pu_ob_t [PU_NUM-1:0]                        ob_bus_t;

  localparam logic signed [OUT_BIN_LEN-1:0] Q_ZERO = OUT_BIN_LEN'(0);
  localparam logic signed [OUT_BIN_LEN-1:0] Q_UMAX = OUT_BIN_LEN'((1 << BIN_LEN) - 1);
  localparam logic signed [OUT_BIN_LEN-1:0] Q_SMAX = OUT_BIN_LEN'((1 << (BIN_LEN - 1)) - 1);
  localparam logic signed [OUT_BIN_LEN-1:0] Q_SMIN = OUT_BIN_LEN'(-(1 << (BIN_LEN - 1)));

  // ReLU mode clamps to the unsigned range; otherwise clamp to the signed range.
  function automatic logic [BIN_LEN-1:0] sat_relu(input logic signed [OUT_BIN_LEN-1:0] v,
                                                  input logic relu_en);
    logic [BIN_LEN-1:0] res;
    if (relu_en) begin
      if (v < Q_ZERO) begin
        res = BIN_LEN'(0);
      end else if (v > Q_UMAX) begin
        res = Q_UMAX[BIN_LEN-1:0];
      end else begin
        res = v[BIN_LEN-1:0];
      end
    end else begin
      if (v < Q_SMIN) begin
        res = Q_SMIN[BIN_LEN-1:0];
      end else if (v > Q_SMAX) begin
        res = Q_SMAX[BIN_LEN-1:0];
      end else begin
        res = v[BIN_LEN-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/delta_controller_output_storer_if.sv
// Tile control, output-buffer and DRAM write bus between the top controller,
// the PUs and the output storer.
interface delta_controller_output_storer_if;
  import delta_pkg::*;

  logic                 start;
  logic                 layer_start;
  logic [31:0]          output_start_address;
  logic                 relu_en;
  ob_bus_t              OB_data;
  logic [PU_NUM-1:0]    OB_r_enable;
  logic                 DRAM_Write;
  logic [31:0]          DRAM_Address;
  logic [WORD_W-1:0]    DRAM_WriteData;
  logic                 DRAM_WriteDone;
  logic                 finished;

  modport slave (
    input  start, layer_start, output_start_address, relu_en, OB_data, DRAM_WriteDone,
    output OB_r_enable, DRAM_Write, DRAM_Address, DRAM_WriteData, finished
  );

  modport master (
    output start, layer_start, output_start_address, relu_en, OB_data, DRAM_WriteDone,
    input  OB_r_enable, DRAM_Write, DRAM_Address, DRAM_WriteData, finished
  );

endinterface

// File: rtl/delta_requant_pack.sv
// Requantizes one PU's OUTPUT_CHANNEL partial sums and packs them into a DRAM
// word, channel j in bits [j*BIN_LEN +: BIN_LEN].
module delta_requant_pack
  import delta_pkg::*;
(
  input  pu_ob_t            i_ob,
  input  logic              i_relu_en,
  output logic [WORD_W-1:0] o_word
);

  for (genvar j = 0; j < OUTPUT_CHANNEL; j++) begin : g_sat
    assign o_word[j*BIN_LEN +: BIN_LEN] = sat_relu(i_ob[j], i_relu_en);
  end

endmodule

// File: rtl/delta_controller_output_storer.sv
// Snapshots all PU output buffers at tile end, requantizes and writes one
// packed word per PU to DRAM, then pulses finished.
module delta_controller_output_storer
  import delta_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  delta_controller_output_storer_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_SNAP    = ST_SNAP;
  localparam logic [2:0] S_PACK    = ST_PACK;
  localparam logic [2:0] S_WR      = ST_WR;
  localparam logic [2:0] S_WAIT_WR = ST_WAIT_WR;
  localparam logic [2:0] S_NEXT    = ST_NEXT;
  localparam logic [2:0] S_DONE    = ST_DONE;

  localparam logic [PU_IDX_W-1:0] LAST_PU = PU_IDX_W'(PU_NUM - 1);

  logic [2:0]          r_state;
  logic [31:0]         r_addr;
  logic [PU_IDX_W-1:0] r_pu_idx;
  logic [WORD_W-1:0]   r_wdata;
  ob_bus_t             r_snap;

  logic [2:0]          w_next_state;
  pu_ob_t              w_sel_ob;
  logic [WORD_W-1:0]   w_pack_word;

  assign w_sel_ob = r_snap[r_pu_idx];

  delta_requant_pack u_pack (
    .i_ob      (w_sel_ob),
    .i_relu_en (bus.relu_en),
    .o_word    (w_pack_word)
  );

  // Next-state decode; DRAM_WriteDone only matters while waiting for it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_SNAP;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_SNAP:  w_next_state = S_PACK;
      S_PACK:  w_next_state = S_WR;
      S_WR:    w_next_state = S_WAIT_WR;
      S_WAIT_WR: begin
        if (bus.DRAM_WriteDone) begin
          w_next_state = S_NEXT;
        end else begin
          w_next_state = S_WAIT_WR;
        end
      end
      S_NEXT: begin
        if (r_pu_idx == LAST_PU) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_PACK;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, write pointer, PU index, snapshot and packed word registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= bus.output_start_address;
      r_pu_idx <= '0;
      r_wdata  <= '0;
      r_snap   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (bus.layer_start) begin
            r_addr <= bus.output_start_address;
          end else begin
            r_addr <= r_addr;
          end
        end
        S_SNAP: begin
          r_snap   <= bus.OB_data;
          r_pu_idx <= '0;
        end
        S_PACK: r_wdata <= w_pack_word;
        S_NEXT: begin
          r_addr <= r_addr + 32'd4;
          if (r_pu_idx != LAST_PU) begin
            r_pu_idx <= r_pu_idx + PU_IDX_W'(1);
          end else begin
            r_pu_idx <= r_pu_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.OB_r_enable    = {PU_NUM{r_state == S_SNAP}};
  assign bus.DRAM_Write     = (r_state == S_WR) || (r_state == S_WAIT_WR);
  assign bus.DRAM_Address   = r_addr;
  assign bus.DRAM_WriteData = r_wdata;
  assign bus.finished       = (r_state == S_DONE);

endmodule

// File: tb/tb_delta_controller_output_storer.sv
// Directed tiles with randomized output-buffer contents, checked against a
// behavioural saturate-and-pack model and an acknowledge-driving DRAM stub.
module tb_delta_controller_output_storer;
  import delta_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  delta_controller_output_storer_if bus ();

  delta_controller_output_storer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int  stable_err  = 0;
  int  fin_count   = 0;
  int  fin_cyc     = 0;
  int  hi_cnt      = 0;
  bit  prev_wr     = 1'b0;
  int  tile_wr_base = 0;
  int  delay_tab[PU_NUM];
  bit  ack_in_wr   = 1'b0;
  int  ob_v[PU_NUM][OUTPUT_CHANNEL];

  localparam logic [31:0] REN_ALL = 32'((64'd1 << PU_NUM) - 64'd1);

  always @(posedge clock) cyc <= cyc + 1;

  // DRAM stub: logs each write, checks it is held stable, and acknowledges it
  // after the per-PU delay (optionally also pulsing an ack in the first cycle).
  always @(negedge clock) begin
    int idx;
    if (bus.DRAM_Write) begin
      if (!prev_wr) begin
        wr_addr.push_back(bus.DRAM_Address);
        wr_data.push_back(bus.DRAM_WriteData);
        hi_cnt = 1;
      end else begin
        hi_cnt++;
        if (bus.DRAM_Address !== wr_addr[$] || bus.DRAM_WriteData !== wr_data[$]) stable_err++;
      end
      idx = wr_addr.size() - 1 - tile_wr_base;
      if (idx < 0 || idx >= PU_NUM) idx = 0;
      bus.DRAM_WriteDone = (hi_cnt >= 2 + delay_tab[idx]) || (ack_in_wr && hi_cnt == 1);
    end else begin
      hi_cnt = 0;
      bus.DRAM_WriteDone = 1'b0;
    end
    if (bus.finished) begin
      fin_count++;
      fin_cyc = cyc;
    end
    prev_wr = bus.DRAM_Write;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(input int v, input bit relu);
    int r;
    if (relu) r = (v < 0) ? 0 : ((v > 255) ? 255 : v);
    else      r = (v < -128) ? -128 : ((v > 127) ? 127 : v);
    return 8'(r);
  endfunction

  function automatic logic [31:0] ref_word(input int p, input bit relu);
    logic [31:0] w;
    w = 32'd0;
    for (int c = 0; c < OUTPUT_CHANNEL; c++) w = w | (32'(ref_q(ob_v[p][c], relu)) << (8 * c));
    return w;
  endfunction

  task automatic load_ob(input bit pu0_fixed);
    for (int p = 0; p < PU_NUM; p++) begin
      for (int c = 0; c < OUTPUT_CHANNEL; c++) begin
        case ($urandom_range(0, 3))
          0:       ob_v[p][c] = int'($urandom_range(0, 65535)) - 32768;
          1:       ob_v[p][c] = int'($urandom_range(0, 600)) - 300;
          2:       ob_v[p][c] = int'($urandom_range(0, 255));
          default: ob_v[p][c] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
    end
    if (pu0_fixed) begin
      ob_v[0][0] = -5; ob_v[0][1] = 300; ob_v[0][2] = 100; ob_v[0][3] = 0;
    end
    for (int p = 0; p < PU_NUM; p++)
      for (int c = 0; c < OUTPUT_CHANNEL; c++) bus.OB_data[p][c] = 16'(ob_v[p][c]);
  endtask

  task automatic set_delays(input int pu, input int d, input bit wr_ack);
    for (int p = 0; p < PU_NUM; p++) delay_tab[p] = 0;
    if (pu >= 0) delay_tab[pu] = d;
    ack_in_wr = wr_ack;
  endtask

  task automatic run_tile(input string tg, input bit relu, input bit pu0_fixed, input bit with_layer,
                          input int start_at, input logic [31:0] exp_base, input int exp_lat);
    logic [31:0] exp_w[PU_NUM];
    int base, fin0, i, nwr, cyc0;
    base = wr_addr.size();
    tile_wr_base = base;
    fin0 = fin_count;
    load_ob(pu0_fixed);
    for (int p = 0; p < PU_NUM; p++) exp_w[p] = ref_word(p, relu);
    @(negedge clock); #1;
    bus.relu_en = relu;
    bus.start = 1'b1;
    bus.layer_start = with_layer;
    @(posedge clock); #1;
    cyc0 = cyc;
    bus.start = 1'b0;
    bus.layer_start = 1'b0;
    i = 0;
    while (fin_count == fin0 && i < 500) begin
      @(negedge clock); #1;
      i++;
      if (i == 1) chk({tg, "_snap_ren"}, 32'(bus.OB_r_enable), REN_ALL);
      if (i == 2)
        for (int p = 0; p < PU_NUM; p++)
          for (int c = 0; c < OUTPUT_CHANNEL; c++) bus.OB_data[p][c] = 16'($urandom);
      bus.start = (i == start_at);
    end
    bus.start = 1'b0;
    chk({tg, "_finished_seen"}, 32'(fin_count - fin0), 32'd1);
    chk({tg, "_latency"}, 32'(fin_cyc - cyc0 + 1), 32'(exp_lat));
    repeat (12) @(negedge clock);
    #1;
    nwr = wr_addr.size() - base;
    chk({tg, "_single_finished"}, 32'(fin_count - fin0), 32'd1);
    chk({tg, "_write_count"}, 32'(nwr), 32'(PU_NUM));
    for (int k = 0; k < PU_NUM && k < nwr; k++) begin
      chk($sformatf("%s_addr%0d", tg, k), wr_addr[base + k], exp_base + 32'(4 * k));
      chk($sformatf("%s_data%0d", tg, k), wr_data[base + k], exp_w[k]);
    end
    if (pu0_fixed && nwr > 0)
      chk({tg, "_pu0_const"}, wr_data[base], relu ? 32'h0064FF00 : 32'h00647FFB);
    chk({tg, "_stable"}, 32'(stable_err), 32'd0);
    chk({tg, "_next_addr"}, bus.DRAM_Address, exp_base + 32'(4 * PU_NUM));
  endtask

  initial begin
    int base, fin0, i;
    bus.start = 1'b0;
    bus.layer_start = 1'b0;
    bus.relu_en = 1'b0;
    bus.output_start_address = 32'h0000_1000;
    bus.OB_data = '0;
    bus.DRAM_WriteDone = 1'b0;
    set_delays(-1, 0, 1'b0);

    repeat (3) @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock); #1;
    chk("rst_write", 32'(bus.DRAM_Write), 32'd0);
    chk("rst_ren", 32'(bus.OB_r_enable), 32'd0);
    chk("rst_finished", 32'(bus.finished), 32'd0);
    chk("rst_addr", bus.DRAM_Address, 32'h0000_1000);
    chk("rst_wdata", bus.DRAM_WriteData, 32'd0);

    run_tile("relu_tile", 1'b1, 1'b1, 1'b0, -1, 32'h0000_1000, 4 * PU_NUM + 2);

    set_delays(3, 5, 1'b0);
    run_tile("sat_delay_tile", 1'b0, 1'b1, 1'b0, -1, 32'h0000_1020, 4 * PU_NUM + 2 + 5);

    set_delays(2, 3, 1'b1);
    run_tile("ignore_tile", 1'b1, 1'b0, 1'b0, 8, 32'h0000_1040, 4 * PU_NUM + 2 + 3);

    set_delays(-1, 0, 1'b0);
    bus.output_start_address = 32'h0000_2000;
    run_tile("layer_tile", 1'b0, 1'b0, 1'b1, -1, 32'h0000_2000, 4 * PU_NUM + 2);

    base = wr_addr.size();
    tile_wr_base = base;
    fin0 = fin_count;
    @(negedge clock); #1;
    bus.start = 1'b1;
    @(negedge clock); #1;
    bus.start = 1'b0;
    i = 0;
    while (wr_addr.size() - base < 4 && i < 200) begin
      @(negedge clock); #1;
      i++;
    end
    chk("midrst_reached_w4", 32'(wr_addr.size() - base), 32'd4);
    reset = 1'b0;
    @(negedge clock); #1;
    chk("midrst_write", 32'(bus.DRAM_Write), 32'd0);
    chk("midrst_addr", bus.DRAM_Address, 32'h0000_2000);
    chk("midrst_finished", 32'(bus.finished), 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    #1;
    chk("midrst_no_finished", 32'(fin_count - fin0), 32'd0);
    chk("midrst_no_more_writes", 32'(wr_addr.size() - base), 32'd4);
    chk("midrst_idle_addr", bus.DRAM_Address, 32'h0000_2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
